shape_batch_reader: RTL and testbench
=====================================

Name: shape_batch_reader

Overview:
- Parametrised successor to the single-record shape reader.
- Fetches a batch of consecutive shape records from the shape RAM. Each record has a stride of 2^DATAB words, and only the first NFIELDS words are fetched.
- Tolerates a configurable RAM read latency and presents each record on a valid/ready output port, so the renderer can apply backpressure.
- Sits between the shape RAM read port and the shape rasteriser / drawing pipeline.

Parameters:
- DATAB, 3: log2 of record stride in words.
- NFIELDS, 5: words fetched per record. Range 1..2^DATAB. Field k is word k of the record.
- ADDRW, 20: RAM address width.
- DATAW, 12: RAM data width and field width.
- NUMW, 12: shape id / count width.
- RAM_LAT, 1: RAM read latency in cycles. Range 1..3.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: begin a batch. Sampled only in IDLE.
- id_first, input, NUMW: first shape id, sampled on start.
- id_count, input, NUMW: number of records, sampled on start. 0 means empty batch.
- ram_address_offset, input, ADDRW: base of the shape table. Must stay stable while busy.
- ram_address, output, ADDRW: read address.
- ram_enable, output, 1: read enable.
- ram_data, input, DATAW: read data, valid RAM_LAT cycles after the address/enable cycle.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle pulse at batch end.
- out_valid, output, 1: record available.
- out_ready, input, 1: consumer accepts the record.
- out_id, output, NUMW: id of the presented record.
- out_last, output, 1: presented record is the last of the batch.
- out_fields, output, NFIELDS*DATAW: field k at bits [k*DATAW +: DATAW].

Behaviour:
- Reset, synchronous, overrides everything:
  - state goes to IDLE.
  - ram_enable, out_valid, out_last, done, busy are 0.
  - out_id, out_fields, ram_address are 0.
  - In-flight read tags are cleared, so data returning after reset is discarded.
  - Reset mid-batch abandons the batch without a done pulse.
- States: IDLE, ISSUE, WAIT, HOLD, FIN.
- IDLE:
  - On start with id_count != 0: latch cur_id = id_first and remaining = id_count, then go to ISSUE with ptr = 0.
  - On start with id_count == 0: go to FIN.
- ISSUE:
  - ram_enable = 1 and ram_address = ((cur_id << DATAB) + ram_address_offset + ptr) mod 2^ADDRW. The shift is widened to ADDRW before adding.
  - ptr increments each cycle for exactly NFIELDS cycles. Words NFIELDS..2^DATAB-1 are never read.
  - After ptr = NFIELDS-1, go to WAIT.
- Capture:
  - A RAM_LAT-deep shift register carries (valid, ptr) tags alongside each issued read.
  - When a tag emerges valid, ram_data is written into field[tag_ptr] on that edge.
- WAIT:
  - ram_enable = 0.
  - When the tag for field NFIELDS-1 is captured, go to HOLD on the same edge.
- HOLD:
  - out_valid = 1. out_fields and out_id are stable until the handshake.
  - out_last = (remaining == 1).
  - Handshake happens on an edge where out_valid && out_ready. On handshake:
    - remaining decrements.
    - cur_id increments mod 2^NUMW; ids wrap from 2^NUMW-1 to 0.
    - If remaining was 1, go to FIN; otherwise go to ISSUE with ptr = 0.
- FIN: done = 1 for one cycle, then go to IDLE. busy is high in FIN.
- Latency: start at edge 0 gives
  - ISSUE in cycles 1..NFIELDS,
  - last capture at the end of cycle NFIELDS+RAM_LAT,
  - out_valid from cycle NFIELDS+RAM_LAT+1.
  - Each subsequent record takes NFIELDS+RAM_LAT+1 cycles after its handshake.
- start while busy is ignored.
- out_ready while out_valid = 0 has no effect.
- out_fields keeps the last record after the batch ends, until the next capture or reset.

Test Plan:
- Basic read, RAM_LAT=1, NFIELDS=5, offset=0x100, id_first=2, id_count=1:
  - Addresses issued must be 0x110..0x114.
  - With memory word a holding a[11:0], out_fields = {0x114,0x113,0x112,0x111,0x110}.
  - out_valid must rise in cycle 7. out_last=1, and done must pulse one cycle after the handshake.
- Batch with backpressure: id_first=4, id_count=3, out_ready held low for 10 cycles on each record.
  - Records must be presented with out_id 4, 5, 6, fields stable while held.
  - out_last must be set only on id 6.
  - Exactly one done pulse.
- Latency sweep, RAM_LAT=3 with a matching 3-cycle RAM model:
  - Fields must land in the correct slots.
  - out_valid first in cycle 9.
- Empty and wrap: id_count=0 must give a done pulse 1 cycle after start with no ram_enable.
  - id_first=0xFFF, id_count=2 must give out_id 0xFFF then 0x000, with addresses wrapped modulo 2^20.
- Reset mid-operation: assert rst while in WAIT with reads in flight.
  - All outputs must be 0 next cycle.
  - Late ram_data must not alter out_fields.
  - No done pulse.
  - A new start must then work normally.
- start while busy: pulse start with different id_first during HOLD.
  - It must be ignored and the batch must complete unchanged.

Source files
------------

// File: rtl/shape_batch_reader.sv
// Batch shape-record reader: fetches the first NFIELDS words of consecutive
// 2^DATAB-word records from the shape RAM and presents each on a valid/ready port.
module shape_batch_reader #(
    parameter int DATAB   = 3,
    parameter int NFIELDS = 5,
    parameter int ADDRW   = 20,
    parameter int DATAW   = 12,
    parameter int NUMW    = 12,
    parameter int RAM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUMW-1:0]          id_first,
    input  logic [NUMW-1:0]          id_count,
    input  logic [ADDRW-1:0]         ram_address_offset,
    output logic [ADDRW-1:0]         ram_address,
    output logic                     ram_enable,
    input  logic [DATAW-1:0]         ram_data,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUMW-1:0]          out_id,
    output logic                     out_last,
    output logic [NFIELDS*DATAW-1:0] out_fields
);

    localparam int PTRW = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(NFIELDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [NUMW-1:0]    cur_id;
    logic [NUMW-1:0]    remaining;
    logic [PTRW-1:0]    ptr;
    logic [DATAW-1:0]   field_q   [NFIELDS];
    logic               tag_valid [RAM_LAT];
    logic [PTRW-1:0]    tag_ptr   [RAM_LAT];

    logic               emerge_valid;
    logic [PTRW-1:0]    emerge_ptr;
    logic               handshake;
    logic [ADDRW-1:0]   issue_addr;

    assign emerge_valid = tag_valid[RAM_LAT-1];
    assign emerge_ptr   = tag_ptr[RAM_LAT-1];
    assign handshake    = (state_q == S_HOLD) && out_ready;
    assign issue_addr   = (ADDRW'(cur_id) << DATAB) + ram_address_offset + ADDRW'(ptr);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (id_count != '0) ? S_ISSUE : S_FIN;
            S_ISSUE: if (ptr == LAST_PTR) state_d = S_WAIT;
            S_WAIT:  if (emerge_valid && (emerge_ptr == LAST_PTR)) state_d = S_HOLD;
            S_HOLD:  if (handshake) state_d = (remaining == NUMW'(1)) ? S_FIN : S_ISSUE;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: field storage is cleared on reset because out_fields must read 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id    <= '0;
            remaining <= '0;
            ptr       <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                tag_valid[i] <= 1'b0;
                tag_ptr[i]   <= '0;
            end
            for (int k = 0; k < NFIELDS; k++) field_q[k] <= '0;
        end else begin
            // Tags travel alongside each read so returning data knows its slot.
            tag_valid[0] <= (state_q == S_ISSUE);
            tag_ptr[0]   <= ptr;
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_ptr[i]   <= tag_ptr[i-1];
            end
            if (emerge_valid) field_q[emerge_ptr] <= ram_data;

            case (state_q)
                S_IDLE: begin
                    if (start && (id_count != '0)) begin
                        cur_id    <= id_first;
                        remaining <= id_count;
                        ptr       <= '0;
                    end
                end
                S_ISSUE: ptr <= ptr + PTRW'(1);
                S_HOLD: begin
                    if (out_ready) begin
                        remaining <= remaining - NUMW'(1);
                        cur_id    <= cur_id + NUMW'(1);
                        ptr       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign out_valid   = (state_q == S_HOLD);
    assign out_last    = (state_q == S_HOLD) && (remaining == NUMW'(1));
    assign ram_enable  = (state_q == S_ISSUE);
    assign ram_address = ram_enable ? issue_addr : '0;
    assign out_id      = cur_id;

    for (genvar k = 0; k < NFIELDS; k++) begin : g_fields
        assign out_fields[k*DATAW +: DATAW] = field_q[k];
    end

endmodule

// File: tb/tb_shape_batch_reader.sv
// Randomized bench for shape_batch_reader: two instances (RAM latency 1 and 3)
// checked against a plain-arithmetic model of records, addresses and timing.
module tb_shape_batch_reader;

    localparam int NF = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] id_first, id_count;
    logic [19:0] off;
    logic        out_ready;
    logic        sel;
    logic [11:0] salt;

    logic [19:0] addr1, addr3;
    logic        en1, en3, busy1, busy3, done1, done3, v1, v3, last1, last3;
    logic [11:0] data1, data3, id1, id3;
    logic [59:0] f1, f3;

    logic [19:0] obs_addr;
    logic        obs_en, obs_busy, obs_done, obs_valid, obs_last;
    logic [11:0] obs_id;
    logic [59:0] obs_fields;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [19:0] addr_q [$];

    always #5 clk = ~clk;

    shape_batch_reader #(.RAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start && !sel), .id_first(id_first), .id_count(id_count),
        .ram_address_offset(off), .ram_address(addr1), .ram_enable(en1), .ram_data(data1),
        .busy(busy1), .done(done1), .out_valid(v1), .out_ready(out_ready),
        .out_id(id1), .out_last(last1), .out_fields(f1));

    shape_batch_reader #(.RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start && sel), .id_first(id_first), .id_count(id_count),
        .ram_address_offset(off), .ram_address(addr3), .ram_enable(en3), .ram_data(data3),
        .busy(busy3), .done(done3), .out_valid(v3), .out_ready(out_ready),
        .out_id(id3), .out_last(last3), .out_fields(f3));

    assign obs_addr   = sel ? addr3 : addr1;
    assign obs_en     = sel ? en3   : en1;
    assign obs_busy   = sel ? busy3 : busy1;
    assign obs_done   = sel ? done3 : done1;
    assign obs_valid  = sel ? v3    : v1;
    assign obs_last   = sel ? last3 : last1;
    assign obs_id     = sel ? id3   : id1;
    assign obs_fields = sel ? f3    : f1;

    // Memory word a holds a[11:0] scrambled by a per-batch salt.
    function automatic logic [11:0] mem_word(input logic [19:0] a);
        return a[11:0] ^ salt;
    endfunction

    function automatic logic [19:0] exp_addr(input logic [11:0] id, input int k);
        return 20'((int'(id) * 8 + int'(off) + k) % (1 << 20));
    endfunction

    // RAM models; idle cycles return junk so stray captures show up.
    logic [11:0] pipe1;
    logic [11:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= en1 ? mem_word(addr1) : 12'($urandom);
        pipe3[0] <= en3 ? mem_word(addr3) : 12'($urandom);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign data1 = pipe1;
    assign data3 = pipe3[2];

    always @(negedge clk) begin
        if (obs_en) addr_q.push_back(obs_addr);
        if (obs_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 1;
        while (!obs_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [59:0] exp_fields(input logic [11:0] id);
        logic [59:0] f;
        f = '0;
        for (int k = 0; k < NF; k++) f[k*12 +: 12] = mem_word(exp_addr(id, k));
        return f;
    endfunction

    task automatic run_batch(input logic [11:0] first, input logic [11:0] cnt,
                             input int hold, input bit poke);
        int lat, cyc, done0;
        logic [11:0] rid;
        logic [59:0] fexp;
        logic [19:0] a;
        lat   = sel ? 3 : 1;
        done0 = done_cnt;
        fexp  = '0;
        addr_q.delete();
        start = 1'b1;
        id_first = first;
        id_count = cnt;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(obs_busy), 64'(1));
        if (cnt == 12'd0) begin
            check("empty_done", 64'(obs_done), 64'(1));
            @(negedge clk);
            check("empty_done_end", 64'(obs_done), 64'(0));
            check("empty_busy_end", 64'(obs_busy), 64'(0));
            check("empty_no_reads", 64'(addr_q.size()), 64'(0));
            return;
        end
        for (int j = 0; j < int'(cnt); j++) begin
            rid  = 12'(int'(first) + j);
            fexp = exp_fields(rid);
            wait_valid(60, cyc);
            check("valid_latency", 64'(cyc), 64'(NF + lat + 1));
            check("out_id", 64'(obs_id), 64'(rid));
            check("out_last", 64'(obs_last), 64'(j == int'(cnt) - 1));
            check("out_fields", 64'(obs_fields), 64'(fexp));
            check("num_reads", 64'(addr_q.size()), 64'(NF));
            for (int k = 0; k < NF; k++) begin
                a = (addr_q.size() > 0) ? addr_q.pop_front() : 20'hFFFFF;
                check("ram_address", 64'(a), 64'(exp_addr(rid, k)));
            end
            addr_q.delete();
            for (int h = 0; h < hold; h++) begin
                if (poke && h == hold / 2) begin
                    start = 1'b1;
                    id_first = ~first;
                    id_count = 12'd7;
                end
                @(negedge clk);
                start = 1'b0;
                check("held_valid", 64'(obs_valid), 64'(1));
                check("held_id", 64'(obs_id), 64'(rid));
                check("held_fields", 64'(obs_fields), 64'(fexp));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("fin_done", 64'(obs_done), 64'(1));
        check("fin_busy", 64'(obs_busy), 64'(1));
        @(negedge clk);
        check("idle_done", 64'(obs_done), 64'(0));
        check("idle_busy", 64'(obs_busy), 64'(0));
        check("idle_valid", 64'(obs_valid), 64'(0));
        check("done_pulses", 64'(done_cnt - done0), 64'(1));
        check("fields_kept", 64'(obs_fields), 64'(fexp));
        check("no_stray_reads", 64'(addr_q.size()), 64'(0));
    endtask

    initial begin
        int done0;
        rst = 1'b1; start = 1'b0; id_first = '0; id_count = '0;
        off = '0; out_ready = 1'b0; sel = 1'b0; salt = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(obs_busy), 64'(0));
        check("rst_valid", 64'(obs_valid), 64'(0));
        check("rst_en", 64'(obs_en), 64'(0));
        check("rst_fields", 64'(obs_fields), 64'(0));
        check("rst_id", 64'(obs_id), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Basic single record, then backpressure with a start poke during HOLD
        off = 20'h00100;
        run_batch(12'd2, 12'd1, 0, 1'b0);
        check("basic_fields", 64'(obs_fields), 64'h114_113_112_111_110);
        run_batch(12'd4, 12'd3, 10, 1'b1);

        // Latency-3 instance with scrambled memory
        sel = 1'b1;
        salt = 12'($urandom);
        off = 20'h02345;
        run_batch(12'h010, 12'd2, 2, 1'b0);

        // Empty batch on both instances, then id/address wrap
        run_batch(12'h055, 12'd0, 0, 1'b0);
        sel = 1'b0;
        run_batch(12'h066, 12'd0, 0, 1'b0);
        off = 20'hFFFF0;
        run_batch(12'hFFF, 12'd2, 1, 1'b0);

        // Reset in WAIT with reads in flight on the latency-3 instance
        sel = 1'b1;
        off = 20'h00400;
        done0 = done_cnt;
        start = 1'b1; id_first = 12'd7; id_count = 12'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 64'(obs_busy), 64'(1));
        check("pre_rst_en", 64'(obs_en), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 64'(obs_busy), 64'(0));
        check("mid_rst_valid", 64'(obs_valid), 64'(0));
        check("mid_rst_last", 64'(obs_last), 64'(0));
        check("mid_rst_done", 64'(obs_done), 64'(0));
        check("mid_rst_en", 64'(obs_en), 64'(0));
        check("mid_rst_addr", 64'(obs_addr), 64'(0));
        check("mid_rst_id", 64'(obs_id), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_data_ignored", 64'(obs_fields), 64'(0));
            check("late_valid", 64'(obs_valid), 64'(0));
        end
        check("rst_no_done", 64'(done_cnt - done0), 64'(0));
        run_batch(12'd9, 12'd2, 1, 1'b0);

        // Randomized batches
        for (int t = 0; t < 8; t++) begin
            sel  = 1'($urandom);
            salt = 12'($urandom);
            off  = 20'($urandom);
            run_batch(12'($urandom), 12'($urandom_range(1, 3)),
                      int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
